// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder.
//   MODE_AUTO / MODE_MANUAL : values of the mode input
//   onehot_msb(idx, n)      : MSB-first one-hot of width 2**n, code k sets bit 2**n-1-k
package scan_decoder_pkg;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    // Largest supported select width; the helper returns a vector this wide and
    // callers cast it down to their own 2**N.
    localparam int unsigned ONEHOT_MAX_N = 8;
    localparam int unsigned ONEHOT_MAX_W = 2 ** ONEHOT_MAX_N;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot_msb(input int unsigned idx,
                                                            input int unsigned n);
        return ONEHOT_MAX_W'(1) << ((2 ** n) - 1 - idx);
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational MSB-first one-hot decoder.
//   idx    : channel index (N bits)
//   valid  : 0 forces the output to all zeros
//   onehot : 2**N-bit one-hot, idx k sets bit 2**N-1-k
module onehot_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]      idx,
    input  logic              valid,
    output logic [2**N-1:0]   onehot
);

    localparam int unsigned W = 2 ** N;

    always_comb begin
        onehot = '0;
        if (valid) begin
            onehot = W'(onehot_msb(32'(idx), N));
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2**N one-hot decoder with a built-in scan sequencer.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   en       : 0 blanks y and freezes the sequencer
//   mode     : MODE_AUTO steps via the prescaler, MODE_MANUAL loads sel_in
//   hold     : auto mode only, freezes prescaler, index and y
//   sel_in   : manual channel index
//   y        : registered one-hot select (optionally active-low)
//   sel      : registered channel index
//   tick     : pulse on each auto-mode index step
//   frame    : pulse on the step that wraps LAST -> 0
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DIV        = 100000,
    parameter int unsigned LAST       = 2 ** N - 1,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              hold,
    input  logic [N-1:0]      sel_in,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      sel,
    output logic              tick,
    output logic              frame
);

    localparam int unsigned W       = 2 ** N;
    localparam int unsigned CW      = $clog2(DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [W-1:0]  Y_IDLE  = {W{ACTIVE_LOW}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sel_q, sel_d;
    logic          tick_q, tick_d;
    logic          frame_q, frame_d;
    logic [W-1:0]  y_q, y_d;
    logic          load_y;
    logic          idx_valid;
    logic [W-1:0]  onehot;

    // Decode the next index so y and sel always update on the same edge.
    onehot_decoder #(
        .N (N)
    ) u_dec (
        .idx    (sel_d),
        .valid  (idx_valid),
        .onehot (onehot)
    );

    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        load_y  = 1'b1;
        if (!en) begin
            cnt_d = '0;
        end else if (mode == MODE_MANUAL) begin
            cnt_d = '0;
            sel_d = sel_in;
        end else if (hold) begin
            load_y = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            // >= also catches an out-of-range index left over from manual mode.
            if (32'(sel_q) >= LAST) begin
                sel_d   = '0;
                frame_d = 1'b1;
            end else begin
                sel_d = sel_q + N'(1);
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Compare at 32 bits so LAST = 2**N-1 does not collapse to a constant.
        idx_valid = en && (32'(sel_d) <= LAST);
        if (load_y) begin
            y_d = ACTIVE_LOW ? ~onehot : onehot;
        end else begin
            y_d = y_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
            y_q     <= Y_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
            y_q     <= y_d;
        end
    end

    assign y     = y_q;
    assign sel   = sel_q;
    assign tick  = tick_q;
    assign frame = frame_q;

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Registered, parametrised N-to-2^N one-hot decoder with a built-in scan sequencer. It drives digit/row selects for multiplexed displays and keypads. Two modes: auto-scan, where an internal prescaler steps the channel index, and manual, where the index is loaded from an input. Outputs are registered, with optional active-low polarity, enable blanking, hold, and a programmable wrap point.

Parameters:
N, 2, select width; output width is 2**N
DIV, 100000, prescaler period in clocks per scan step; legal range is 1 or more
LAST, 2**N-1, highest channel index scanned; legal range is 0..2**N-1
ACTIVE_LOW, 0, 1 inverts every bit of y (inactive = 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  enable; 0 blanks y and freezes the sequencer
mode  input  1  0 = auto-scan, 1 = manual
hold  input  1  auto mode only: freezes the prescaler and index; y keeps its value
sel_in  input  N  manual channel index
y  output  2**N  one-hot select; code k asserts y[2**N-1-k] (MSB-first ordering)
sel  output  N  current registered channel index
tick  output  1  one-cycle pulse on the edge where the index advances in auto mode
frame  output  1  one-cycle pulse on the edge where the index wraps from LAST to 0

Behaviour:
- Reset (async, any time, including mid-scan): cnt=0, sel=0, tick=0, frame=0, y=all inactive (0s, or all 1s if ACTIVE_LOW).
- First edge after reset release with en=1: y decodes sel=0.
- Prescaler cnt counts 0..DIV-1 while en=1, mode=0 and hold=0.
  - At cnt==DIV-1 it returns to 0 and asserts step.
  - DIV=1: step every cycle.
- On step, sel <= (sel==LAST) ? 0 : sel+1. tick=1 on that same edge; frame=1 only on the wrap.
- If sel>LAST on entry to auto mode, the next step wraps to 0 and frame=1.
- Manual mode (mode=1, en=1):
  - sel <= sel_in every edge; latency is 1 clock.
  - cnt is held at 0; tick=frame=0.
  - sel_in>LAST: sel still loads, but y is all inactive.
- Mode change manual to auto: cnt restarts from 0; sel continues from the last manual value.
- Mode change auto to manual: takes effect on the next edge; no tick is generated.
- hold=1 in auto mode: cnt, sel and y are frozen; tick=frame=0. hold is ignored in manual mode.
- en=0: cnt is forced to 0, sel is held, tick=frame=0, and y is all inactive on the next edge.
- en rising: y decodes the held sel on the next edge; the first step comes DIV clocks later.
- y is registered and updates on the same edge as sel, so y always matches the registered sel.
  - Rule: y = ACTIVE_LOW ? ~onehot : onehot, where onehot = en && sel<=LAST ? (1 << (2**N-1-sel)) : 0.
- Widths: cnt is $clog2(DIV+1) bits; the index arithmetic is N bits with no overflow (explicit wrap at LAST).
- Simultaneous step and wrap: tick and frame are both 1 on that edge.

Decomposition:
- Package scan_decoder_pkg holds:
  - mode constants MODE_AUTO=1'b0 and MODE_MANUAL=1'b1
  - function onehot_msb(idx, n) returning the MSB-first one-hot vector
- Sub-module onehot_decoder: combinational, parameter N, inputs idx and valid, output onehot. It is instantiated once and feeds the y register.
- The prescaler and index logic stay in the top module.

Test Plan (N=2, DIV=4, LAST=3, ACTIVE_LOW=0 unless stated):
- Auto scan: rst pulse, then en=1, mode=0.
  - y=1000 after the first edge.
  - y steps 1000, 0100, 0010, 0001, 1000 every 4 clocks.
  - tick on each step; frame only on the 0001 to 1000 step.
- Wrap point: LAST=2, auto mode. Sequence is 1000, 0100, 0010, 1000; y never equals 0001; frame on the 2 to 0 step.
- Manual mode: mode=1, sel_in=3, giving y=0001 and sel=3 one edge later.
  - sel_in=1 then gives y=0100.
  - With LAST=2 and sel_in=3: sel=3, y=0000, tick=0.
- Blank and hold:
  - en=0 mid-scan at sel=2: y=0000 next edge, sel stays 2. en=1: y=0010, and the next step comes 4 clocks later.
  - hold=1 for 10 clocks: y unchanged, no tick.
- Active-low: ACTIVE_LOW=1, auto scan gives 0111, 1011, 1101, 1110; en=0 gives 1111.
- Async reset mid-operation: assert rst between edges while sel=2. y, sel, tick and frame go to reset values immediately, without waiting for a clock edge; scan resumes at sel=0 after release.
